usb1_reg_arb: RTL and testbench



---
 rtl/usb1_reg_arb.sv | 196 +++++++++++++++++++
 tb/tb_usb1_reg_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb1_reg_arb.sv
// usb1_reg_arb: round-robin arbiter letting two requesters share the
// usbh_core register port (usb_clk domain), with a bus timeout.
//
// Ports:
//   usb_clk_i, usb_rst_i            clock, synchronous active-high reset
//   m0_*/m1_* cs,wr,addr,wdata,be   requester command inputs
//   m0_*/m1_* rdata,ack,err         requester completion outputs
//   reg_cs,wr,addr,wdata,be         registered command to the core
//   reg_rdata, reg_ack              core response
//   timeout_cnt                     saturating count of timeouts
module usb1_reg_arb #(
    parameter int              AW      = 6,
    parameter int              DW      = 32,
    parameter int              TIMEOUT = 255,
    parameter logic [DW-1:0]   TO_DATA = 32'hDEAD_0BAD
) (
    input  logic              usb_clk_i,
    input  logic              usb_rst_i,

    input  logic              m0_cs,
    input  logic              m0_wr,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_be,
    output logic [DW-1:0]     m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_cs,
    input  logic              m1_wr,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_be,
    output logic [DW-1:0]     m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,

    output logic              reg_cs,
    output logic              reg_wr,
    output logic [AW-1:0]     reg_addr,
    output logic [DW-1:0]     reg_wdata,
    output logic [DW/8-1:0]   reg_be,
    input  logic [DW-1:0]     reg_rdata,
    input  logic              reg_ack,

    output logic [7:0]        timeout_cnt
);

    localparam int BW = DW / 8;
    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cs_q, cs_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   rd0_q, rd0_d;
    logic [DW-1:0]   rd1_q, rd1_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            err0_q, err0_d;
    logic            err1_q, err1_d;
    logic [7:0]      tocnt_q, tocnt_d;

    // m1 wins if it is the only requester, or on a tie when m0 went last.
    logic gnt1;
    assign gnt1 = m1_cs & (~m0_cs | ~last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        tocnt_d = tocnt_q;

        unique case (state_q)
            IDLE: begin
                if (m0_cs | m1_cs) begin
                    last_d  = gnt1;
                    cs_d    = 1'b1;
                    wr_d    = gnt1 ? m1_wr    : m0_wr;
                    addr_d  = gnt1 ? m1_addr  : m0_addr;
                    wdata_d = gnt1 ? m1_wdata : m0_wdata;
                    be_d    = gnt1 ? m1_be    : m0_be;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // last_q names the master owning this transaction.
                if (reg_ack) begin
                    cs_d    = 1'b0;
                    state_d = DONE;
                    if (last_q) begin
                        rd1_d  = reg_rdata;
                        ack1_d = 1'b1;
                    end else begin
                        rd0_d  = reg_rdata;
                        ack0_d = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cs_d    = 1'b0;
                    state_d = DONE;
                    if (tocnt_q != 8'hFF) begin
                        tocnt_d = tocnt_q + 8'd1;
                    end
                    if (last_q) begin
                        rd1_d  = TO_DATA;
                        err1_d = 1'b1;
                    end else begin
                        rd0_d  = TO_DATA;
                        err0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge usb_clk_i) begin
        if (usb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            tocnt_q <= tocnt_d;
        end
    end

    assign reg_cs      = cs_q;
    assign reg_wr      = wr_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_be      = be_q;
    assign m0_rdata    = rd0_q;
    assign m1_rdata    = rd1_q;
    assign m0_ack      = ack0_q;
    assign m1_ack      = ack1_q;
    assign m0_err      = err0_q;
    assign m1_err      = err1_q;
    assign timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_usb1_reg_arb.sv
// tb_usb1_reg_arb: directed self-checking bench for usb1_reg_arb.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_usb1_reg_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_cs = 1'b0, m1_cs = 1'b0;
    logic        m0_wr = 1'b0, m1_wr = 1'b0;
    logic [5:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        reg_cs, reg_wr;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack = 1'b0;
    logic [7:0]  timeout_cnt;

    int n_checks = 0;
    int n_errors = 0;

    usb1_reg_arb dut (
        .usb_clk_i   (clk),
        .usb_rst_i   (rst),
        .m0_cs       (m0_cs),
        .m0_wr       (m0_wr),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_be       (m0_be),
        .m0_rdata    (m0_rdata),
        .m0_ack      (m0_ack),
        .m0_err      (m0_err),
        .m1_cs       (m1_cs),
        .m1_wr       (m1_wr),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_be       (m1_be),
        .m1_rdata    (m1_rdata),
        .m1_ack      (m1_ack),
        .m1_err      (m1_err),
        .reg_cs      (reg_cs),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_be      (reg_be),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_cs   = 1'b0;
        m1_cs   = 1'b0;
        reg_ack = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
    endtask

    // Simple core: acks core_lat cycles after reg_cs rises,
    // returning the zero-extended address as read data.
    bit core_en  = 1'b0;
    int core_lat = 1;
    int core_w   = 0;
    always @(posedge clk) begin
        #1;
        if (core_en) begin
            if (reg_cs && !reg_ack) begin
                core_w++;
                if (core_w == core_lat) begin
                    reg_ack   = 1'b1;
                    reg_rdata = {26'b0, reg_addr};
                    core_w    = 0;
                end
            end else begin
                reg_ack = 1'b0;
                core_w  = 0;
            end
        end
    end

    // Grant order recorder and ack/err exclusivity monitor.
    bit         rec_en  = 1'b0;
    logic       cs_prev = 1'b0;
    logic [5:0] grants[$];
    int         excl_bad = 0;
    always @(posedge clk) begin
        #1;
        if (rec_en && reg_cs && !cs_prev) grants.push_back(reg_addr);
        cs_prev = reg_cs;
    end
    always @(negedge clk) begin
        if (int'(m0_ack) + int'(m1_ack) + int'(m0_err) + int'(m1_err) > 1)
            excl_bad++;
    end

    logic [5:0] exp_order [8] = '{6'h10, 6'h20, 6'h11, 6'h21,
                                  6'h12, 6'h22, 6'h13, 6'h23};
    int acks0 = 0, acks1 = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // ---- reset state
        do_reset();
        check("rst reg_cs", reg_cs, 0);
        check("rst tocnt", timeout_cnt, 0);
        check("rst m0_rdata", m0_rdata, 0);
        check("rst acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);

        // ---- single m0 write, core acks after 3 cycles of reg_cs
        m0_wr = 1'b1; m0_addr = 6'h04; m0_wdata = 32'h0000_0001;
        m0_be = 4'hF; m0_cs = 1'b1;
        m1_wr = 1'b1; m1_addr = 6'h3F; m1_wdata = 32'hFFFF_FFFF;
        tick();
        check("t1 cs0", reg_cs, 1);
        check("t1 fields", {reg_wr, reg_addr, reg_be}, {1'b1, 6'h04, 4'hF});
        check("t1 wdata", reg_wdata, 32'h1);
        tick();
        check("t1 cs1", reg_cs, 1);
        tick();
        check("t1 cs2", reg_cs, 1);
        reg_ack = 1'b1;
        reg_rdata = 32'h5555_AAAA;
        tick();
        check("t1 cs3", reg_cs, 0);
        check("t1 m0_ack", m0_ack, 1);
        check("t1 others", {m1_ack, m0_err, m1_err}, 0);
        reg_ack = 1'b0;
        m0_cs = 1'b0;
        tick();
        check("t1 ack pulse", m0_ack, 0);

        // ---- simultaneous reads after reset: m0 first
        do_reset();
        core_en = 1'b1; core_lat = 1;
        m0_wr = 1'b0; m0_addr = 6'h11; m0_cs = 1'b1;
        m1_wr = 1'b0; m1_addr = 6'h22; m1_cs = 1'b1;
        tick();
        check("t2 gnt m0", {reg_cs, reg_wr, reg_addr}, {1'b1, 1'b0, 6'h11});
        tick();
        check("t2 m0_ack", {m0_ack, m1_ack}, 2'b10);
        check("t2 m0_rdata", m0_rdata, 32'h11);
        m0_cs = 1'b0;
        tick();
        check("t2 gap", reg_cs, 0);
        tick();
        check("t2 gnt m1", {reg_cs, reg_addr}, {1'b1, 6'h22});
        tick();
        check("t2 m1_ack", {m0_ack, m1_ack}, 2'b01);
        check("t2 m1_rdata", m1_rdata, 32'h22);
        m1_cs = 1'b0;
        tick();
        tick();

        // ---- 4 back-to-back requests per master
        do_reset();
        core_lat = 3;
        grants.delete();
        rec_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    int w = 0;
                    m0_addr = 6'h10 + 6'(k);
                    m0_cs = 1'b1;
                    do begin tick(); w++; end
                    while (!m0_ack && !m0_err && w < 50);
                    check("t3 m0 done", m0_ack, 1);
                    check("t3 m0 rdata", m0_rdata, 32'h10 + 32'(k));
                    if (m0_ack) acks0++;
                end
                m0_cs = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    int w = 0;
                    m1_addr = 6'h20 + 6'(k);
                    m1_cs = 1'b1;
                    do begin tick(); w++; end
                    while (!m1_ack && !m1_err && w < 50);
                    check("t3 m1 done", m1_ack, 1);
                    check("t3 m1 rdata", m1_rdata, 32'h20 + 32'(k));
                    if (m1_ack) acks1++;
                end
                m1_cs = 1'b0;
            end
        join
        tick();
        rec_en = 1'b0;
        core_en = 1'b0;
        check("t3 acks", acks0 + acks1, 8);
        check("t3 ngrants", grants.size(), 8);
        for (int i = 0; i < 8; i++) begin
            logic [5:0] g;
            g = (i < grants.size()) ? grants[i] : 6'h00;
            check("t3 order", g, exp_order[i]);
        end

        // ---- m1 read with no ack: timeout
        reg_ack = 1'b0;
        m1_wr = 1'b0; m1_addr = 6'h05; m1_cs = 1'b1;
        tick();
        n = 0;
        while (reg_cs && n < 300) begin
            n++;
            tick();
        end
        check("t4 busy cycles", n, 255);
        check("t4 err", {m1_err, m1_ack, m0_err, m0_ack}, 4'b1000);
        check("t4 rdata", m1_rdata, 32'hDEAD_0BAD);
        check("t4 tocnt", timeout_cnt, 1);
        m1_cs = 1'b0;
        reg_ack = 1'b1;
        tick();
        check("t4 late ack", {m1_ack, m1_err, reg_cs}, 0);
        tick();
        check("t4 late ack2", {m1_ack, m1_err, reg_cs}, 0);
        reg_ack = 1'b0;
        check("t4 tocnt hold", timeout_cnt, 1);
        check("t4 rdata hold", m1_rdata, 32'hDEAD_0BAD);

        // ---- ack on the expiry cycle wins
        m0_wr = 1'b0; m0_addr = 6'h07; m0_cs = 1'b1;
        reg_rdata = 32'hCAFE_F00D;
        tick();
        for (int i = 0; i < 254; i++) tick();
        check("t5 still busy", reg_cs, 1);
        reg_ack = 1'b1;
        tick();
        check("t5 ack", {m0_ack, m0_err}, 2'b10);
        check("t5 rdata", m0_rdata, 32'hCAFE_F00D);
        check("t5 tocnt", timeout_cnt, 1);
        reg_ack = 1'b0;
        m0_cs = 1'b0;
        tick();

        // ---- reset pulse while busy
        m0_wr = 1'b1; m0_addr = 6'h09; m0_cs = 1'b1;
        tick();
        check("t6 busy", reg_cs, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 cs drop", reg_cs, 0);
        check("t6 no ack", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        check("t6 tocnt", timeout_cnt, 0);
        check("t6 rdata clr", m0_rdata, 0);
        m0_addr = 6'h0A;
        m1_wr = 1'b1; m1_addr = 6'h0B; m1_cs = 1'b1;
        tick();
        check("t6 gnt m0", {reg_cs, reg_addr}, {1'b1, 6'h0A});
        reg_rdata = 32'h0000_00AA;
        reg_ack = 1'b1;
        tick();
        check("t6 m0_ack", {m0_ack, m1_ack}, 2'b10);
        reg_ack = 1'b0;
        m0_cs = 1'b0;
        m1_cs = 1'b0;
        tick();
        tick();

        check("excl", excl_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
